// File: rtl/game_timers_pkg.sv
// Shared constants for the game datapath and its controller.
//   STEP_W_DEF      : width of step/level counters
//   MAX_LEVEL_DEF   : level at which the game is won
//   TICK_CYCLES_DEF : clock cycles per prescaler tick (1 s at 50 MHz)
//   SHOW_TICKS_DEF  : ticks each FPGA symbol stays on display
//   TIMEOUT_TICKS_DEF : idle ticks before the user times out
package game_timers_pkg;

    localparam int unsigned STEP_W_DEF        = 4;
    localparam int unsigned MAX_LEVEL_DEF     = 15;
    localparam int unsigned TICK_CYCLES_DEF   = 50_000_000;
    localparam int unsigned SHOW_TICKS_DEF    = 1;
    localparam int unsigned TIMEOUT_TICKS_DEF = 5;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running prescaler producing a one-cycle tick every TICK_CYCLES clocks.
// Ports:
//   CLOCK : system clock, rising edge
//   reset : synchronous active-high reset
//   clr   : synchronous clear of the count (round restart)
//   tick  : registered 1-cycle pulse, high while the count sits at TICK_CYCLES-1
module tick_prescaler
    import game_timers_pkg::*;
#(
    parameter int unsigned TICK_CYCLES = TICK_CYCLES_DEF
) (
    input  logic CLOCK,
    input  logic reset,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CW = cnt_width(TICK_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(TICK_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_q, tick_d;

    always_comb begin
        cnt_d  = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
        if (clr) begin
            cnt_d = '0;
        end
        // Registered decode of the next count so tick lines up with cnt == last.
        tick_d = (cnt_d == CNT_LAST);
    end

    always_ff @(posedge CLOCK) begin
        if (reset) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/game_timers.sv
// Counter/timer datapath driven by the game controller.
// Ports:
//   CLOCK, reset            : clock and synchronous active-high reset
//   R1                      : round clear (steps, prescaler, show/time counters, end_* flags)
//   R2                      : game clear (level, win)
//   E1 / E2 / E4            : enable playback / user step / user timeout counting
//   E3                      : level advance pulse
//   user_strobe             : one pulse per user symbol entry
//   step_FPGA, step_User    : playback and entry symbol indices
//   level                   : current level (round length = level+1)
//   tick                    : prescaler pulse
//   end_FPGA, end_User, end_time : sticky round-completion flags
//   win                     : level reached MAX_LEVEL
module game_timers
    import game_timers_pkg::*;
#(
    parameter int unsigned TICK_CYCLES   = TICK_CYCLES_DEF,
    parameter int unsigned SHOW_TICKS    = SHOW_TICKS_DEF,
    parameter int unsigned TIMEOUT_TICKS = TIMEOUT_TICKS_DEF,
    parameter int unsigned STEP_W        = STEP_W_DEF,
    parameter int unsigned MAX_LEVEL     = MAX_LEVEL_DEF
) (
    input  logic              CLOCK,
    input  logic              reset,
    input  logic              R1,
    input  logic              R2,
    input  logic              E1,
    input  logic              E2,
    input  logic              E3,
    input  logic              E4,
    input  logic              user_strobe,
    output logic [STEP_W-1:0] step_FPGA,
    output logic [STEP_W-1:0] step_User,
    output logic [STEP_W-1:0] level,
    output logic              tick,
    output logic              end_FPGA,
    output logic              end_User,
    output logic              end_time,
    output logic              win
);

    localparam int unsigned SW = cnt_width(SHOW_TICKS);
    localparam int unsigned TW = cnt_width(TIMEOUT_TICKS);
    localparam logic [SW-1:0]     SHOW_LAST    = SW'(SHOW_TICKS - 1);
    localparam logic [TW-1:0]     TIMEOUT_LAST = TW'(TIMEOUT_TICKS - 1);
    localparam logic [STEP_W-1:0] LEVEL_MAX    = STEP_W'(MAX_LEVEL);

    logic [SW-1:0]     show_cnt_q, show_cnt_d;
    logic [TW-1:0]     time_cnt_q, time_cnt_d;
    logic [STEP_W-1:0] step_fpga_q, step_fpga_d;
    logic [STEP_W-1:0] step_user_q, step_user_d;
    logic [STEP_W-1:0] level_q, level_d;
    logic              end_fpga_q, end_fpga_d;
    logic              end_user_q, end_user_d;
    logic              end_time_q, end_time_d;
    logic              win_q, win_d;
    logic              accept;

    tick_prescaler #(
        .TICK_CYCLES(TICK_CYCLES)
    ) u_prescaler (
        .CLOCK(CLOCK),
        .reset(reset),
        .clr  (R1),
        .tick (tick)
    );

    // Any enabled strobe restarts the idle timer, even once entry is complete.
    assign accept = E2 & user_strobe;

    always_comb begin
        show_cnt_d  = show_cnt_q;
        time_cnt_d  = time_cnt_q;
        step_fpga_d = step_fpga_q;
        step_user_d = step_user_q;
        level_d     = level_q;
        end_fpga_d  = end_fpga_q;
        end_user_d  = end_user_q;
        end_time_d  = end_time_q;
        win_d       = (level_q == LEVEL_MAX);

        // Playback: each symbol is shown for SHOW_TICKS ticks; last symbol sets end_FPGA.
        if (E1 && !end_fpga_q && tick) begin
            if (show_cnt_q == SHOW_LAST) begin
                show_cnt_d = '0;
                if (step_fpga_q == level_q) begin
                    end_fpga_d = 1'b1;
                end else begin
                    step_fpga_d = step_fpga_q + 1'b1;
                end
            end else begin
                show_cnt_d = show_cnt_q + 1'b1;
            end
        end

        // User entry.
        if (accept && !end_user_q) begin
            if (step_user_q == level_q) begin
                end_user_d = 1'b1;
            end else begin
                step_user_d = step_user_q + 1'b1;
            end
        end

        // Timeout: a strobe outranks a coincident tick or expiry.
        if (!E4) begin
            time_cnt_d = '0;
        end else if (!end_time_q) begin
            if (accept) begin
                time_cnt_d = '0;
            end else if (tick) begin
                if (time_cnt_q == TIMEOUT_LAST) begin
                    end_time_d = 1'b1;
                end else begin
                    time_cnt_d = time_cnt_q + 1'b1;
                end
            end
        end

        // Level advance saturates at the winning level.
        if (E3 && (level_q != LEVEL_MAX)) begin
            level_d = level_q + 1'b1;
        end

        if (R1) begin
            show_cnt_d  = '0;
            time_cnt_d  = '0;
            step_fpga_d = '0;
            step_user_d = '0;
            end_fpga_d  = 1'b0;
            end_user_d  = 1'b0;
            end_time_d  = 1'b0;
        end

        if (R2) begin
            level_d = '0;
            win_d   = 1'b0;
        end
    end

    always_ff @(posedge CLOCK) begin
        if (reset) begin
            show_cnt_q  <= '0;
            time_cnt_q  <= '0;
            step_fpga_q <= '0;
            step_user_q <= '0;
            level_q     <= '0;
            end_fpga_q  <= 1'b0;
            end_user_q  <= 1'b0;
            end_time_q  <= 1'b0;
            win_q       <= 1'b0;
        end else begin
            show_cnt_q  <= show_cnt_d;
            time_cnt_q  <= time_cnt_d;
            step_fpga_q <= step_fpga_d;
            step_user_q <= step_user_d;
            level_q     <= level_d;
            end_fpga_q  <= end_fpga_d;
            end_user_q  <= end_user_d;
            end_time_q  <= end_time_d;
            win_q       <= win_d;
        end
    end

    assign step_FPGA = step_fpga_q;
    assign step_User = step_user_q;
    assign level     = level_q;
    assign end_FPGA  = end_fpga_q;
    assign end_User  = end_user_q;
    assign end_time  = end_time_q;
    assign win       = win_q;

endmodule

// File: tb/tb_game_timers.sv
module tb_game_timers;

    localparam int unsigned STEP_W = 4;

    logic              CLOCK = 1'b0;
    logic              reset, R1, R2, E1, E2, E3, E4, user_strobe;
    logic [STEP_W-1:0] step_FPGA, step_User, level;
    logic              tick, end_FPGA, end_User, end_time, win;

    int n_tests = 0;
    int n_fail  = 0;

    game_timers #(
        .TICK_CYCLES  (4),
        .SHOW_TICKS   (2),
        .TIMEOUT_TICKS(3),
        .STEP_W       (STEP_W),
        .MAX_LEVEL    (3)
    ) dut (
        .CLOCK      (CLOCK),
        .reset      (reset),
        .R1         (R1),
        .R2         (R2),
        .E1         (E1),
        .E2         (E2),
        .E3         (E3),
        .E4         (E4),
        .user_strobe(user_strobe),
        .step_FPGA  (step_FPGA),
        .step_User  (step_User),
        .level      (level),
        .tick       (tick),
        .end_FPGA   (end_FPGA),
        .end_User   (end_User),
        .end_time   (end_time),
        .win        (win)
    );

    always #5 CLOCK = ~CLOCK;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the last one.
    task automatic cyc(input int n);
        repeat (n) @(posedge CLOCK);
        #1;
    endtask

    task automatic pulse(input int which);
        case (which)
            1: R1 = 1'b1;
            2: R2 = 1'b1;
            3: E3 = 1'b1;
            default: user_strobe = 1'b1;
        endcase
        cyc(1);
        R1 = 1'b0; R2 = 1'b0; E3 = 1'b0; user_strobe = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_all"},
                 int'({step_FPGA, step_User, level, tick, end_FPGA, end_User, end_time, win}), 0);
    endtask

    initial begin
        reset = 1'b1; R1 = 0; R2 = 0; E1 = 0; E2 = 0; E3 = 0; E4 = 0; user_strobe = 0;
        cyc(1);
        check_all_zero("reset");
        reset = 1'b0;

        // Prescaler: tick high after the 3rd edge past reset, period 4.
        cyc(2); check_eq("tick_lo0", tick, 0);
        cyc(1); check_eq("tick_hi1", tick, 1);
        cyc(1); check_eq("tick_lo1", tick, 0);
        cyc(3); check_eq("tick_hi2", tick, 1);

        // Playback at level 1; R1 and E3 together both take effect.
        R1 = 1'b1; E3 = 1'b1; cyc(1); R1 = 1'b0; E3 = 1'b0;
        check_eq("lvl1", level, 1);
        check_eq("tick_clr", tick, 0);
        E1 = 1'b1;
        cyc(7);  check_eq("pb_step0", step_FPGA, 0);
        cyc(1);  check_eq("pb_step1", step_FPGA, 1);
        cyc(7);  check_eq("pb_end_lo", end_FPGA, 0);
        cyc(1);  check_eq("pb_end_hi", end_FPGA, 1);
        check_eq("pb_step_end", step_FPGA, 1);
        cyc(8);  check_eq("pb_hold", step_FPGA, 1);
        E1 = 1'b0;

        // User entry at level 2.
        R1 = 1'b1; E3 = 1'b1; cyc(1); R1 = 1'b0; E3 = 1'b0;
        check_eq("r1_endf", end_FPGA, 0);
        check_eq("r1_stepf", step_FPGA, 0);
        check_eq("lvl2", level, 2);
        pulse(4); check_eq("usr_e2off", step_User, 0);
        E2 = 1'b1;
        pulse(4); check_eq("usr_s1", step_User, 1);
        cyc(2);
        pulse(4); check_eq("usr_s2", step_User, 2);
        check_eq("usr_end_lo", end_User, 0);
        pulse(4); check_eq("usr_end_hi", end_User, 1);
        check_eq("usr_s3", step_User, 2);
        pulse(4); check_eq("usr_s4", step_User, 2);
        E2 = 1'b0;

        // Timeout with no strobes.
        pulse(1);
        check_eq("r1_endu", end_User, 0);
        E4 = 1'b1;
        cyc(11); check_eq("to_lo", end_time, 0);
        cyc(1);  check_eq("to_hi", end_time, 1);

        // Strobe on the 2nd tick restarts the timeout.
        E4 = 1'b0;
        pulse(1);
        check_eq("r1_endt", end_time, 0);
        E4 = 1'b1; E2 = 1'b1;
        cyc(7);  check_eq("to2_tick", tick, 1);
        pulse(4);
        cyc(11); check_eq("to2_lo", end_time, 0);
        cyc(1);  check_eq("to2_hi", end_time, 1);
        E2 = 1'b0;

        // Level saturation and win; R1 with R2 clears both groups.
        pulse(2);
        check_eq("r2_lvl", level, 0);
        check_eq("r2_win", win, 0);
        pulse(3); check_eq("lv_a", level, 1);
        pulse(3); check_eq("lv_b", level, 2);
        pulse(3); check_eq("lv_c", level, 3);
        check_eq("win_lo", win, 0);
        pulse(3); check_eq("lv_d", level, 3);
        check_eq("win_hi", win, 1);
        check_eq("endt_pre", end_time, 1);
        R1 = 1'b1; R2 = 1'b1; cyc(1); R1 = 1'b0; R2 = 1'b0;
        check_eq("r12_lvl", level, 0);
        check_eq("r12_win", win, 0);
        check_eq("r12_endt", end_time, 0);
        E4 = 1'b0;

        // Reset mid-playback with end_User set clears everything.
        pulse(3); pulse(3); pulse(3);
        E2 = 1'b1;
        repeat (4) pulse(4);
        check_eq("pre_endu", end_User, 1);
        cyc(1);
        check_eq("pre_win", win, 1);
        E1 = 1'b1;
        cyc(9);
        reset = 1'b1; cyc(1); reset = 1'b0;
        check_all_zero("midreset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
